conv_tile_sched: RTL and testbench
==================================

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

Interface
REQ-001 SHALL have parameter CW, default 16: width of tile base coordinates and tile counter.
REQ-002 SHALL have parameter N, default 32: output-channel extent of the layer.
REQ-003 SHALL have parameter M, default 32: input-channel extent of the layer.
REQ-004 SHALL have parameter R, default 64: feature-map row extent.
REQ-005 SHALL have parameter C, default 32: feature-map column extent.
REQ-006 SHALL have parameters Tn=16, Tm=16, Tr=64, Tc=16: tile steps; N, M, R and C SHALL be integer multiples of Tn, Tm, Tr and Tc respectively.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port sched_start, input, 1: one-cycle request to process the whole layer.
REQ-010 SHALL have port sched_done, output, 1: one-cycle pulse after the last tile completes.
REQ-011 SHALL have port sched_busy, output, 1: high from acceptance of a start until sched_done.
REQ-012 SHALL have port conv_tile_start, output, 1: one-cycle tile launch pulse.
REQ-013 SHALL have port conv_tile_done, input, 1: tile completion pulse.
REQ-014 SHALL have ports tile_base_n, tile_base_m, tile_base_row, tile_base_col, output, CW bits each: current tile origin.
REQ-015 SHALL have port tile_cnt, output, CW bits: number of tiles completed in the current layer.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, NEXT and FIN.
REQ-017 IDLE SHALL go to ISSUE on sched_start, and SHALL load all bases and tile_cnt with 0 on that edge.
REQ-018 ISSUE SHALL assert conv_tile_start for exactly one cycle, then go to WAIT.
REQ-019 WAIT SHALL go to NEXT on the first cycle in which conv_tile_done=1.
REQ-020 NEXT SHALL increment tile_cnt and advance the bases in this order:
  - m is innermost, stepping by Tm;
  - then col, stepping by Tc;
  - then row, stepping by Tr;
  - n is outermost, stepping by Tn.
REQ-021 A coordinate reaching its extent SHALL wrap to 0 and carry into the next-outer coordinate.
REQ-022 From NEXT, the FSM SHALL go to ISSUE if tiles remain; otherwise it SHALL go to FIN.
REQ-023 FIN SHALL pulse sched_done for one cycle and return to IDLE; bases and tile_cnt SHALL hold their final values.
REQ-024 Total tiles SHALL equal (N/Tn)*(M/Tm)*(R/Tr)*(C/Tc).
REQ-025 Latency from conv_tile_done to the next conv_tile_start SHALL be 2 cycles (NEXT, ISSUE).
REQ-026 Latency from sched_start to the first conv_tile_start SHALL be 1 cycle.
REQ-027 Bases SHALL be stable from the ISSUE cycle until the NEXT edge.
REQ-028 sched_start SHALL be ignored outside IDLE.
REQ-029 conv_tile_done SHALL be ignored outside WAIT, including when it coincides with ISSUE.
REQ-030 sched_busy SHALL be 1 in ISSUE, WAIT, NEXT and FIN, and 0 in IDLE.
REQ-031 Last-tile detection SHALL be combinational on the coordinates, not on tile_cnt, so tile_cnt width cannot cause an early finish.
REQ-032 Coordinate additions SHALL be CW bits; an extent of 2^CW or more SHALL be treated as a configuration error and is not supported.

Reset
REQ-033 rst low SHALL immediately force state to IDLE.
REQ-034 rst low SHALL drive conv_tile_start, sched_done and sched_busy to 0.
REQ-035 rst low SHALL drive all bases and tile_cnt to 0.
REQ-036 Reset asserted mid-layer SHALL abandon the layer with no sched_done; the next sched_start SHALL restart from tile 0.

Configuration
REQ-037 With macro TILE_SCHED_PERF_CNT_EN defined, the block SHALL add output busy_cycles (32 bits):
  - cleared on an accepted sched_start;
  - incremented every cycle in WAIT;
  - held after FIN;
  - reset to 0.
REQ-038 Without TILE_SCHED_PERF_CNT_EN, the busy_cycles port and its counter SHALL be absent.

Verification
REQ-039 Default parameters; sched_start; conv_tile_done 10 cycles after each launch -> 8 conv_tile_start pulses.
  - (n,m,row,col) sequence: (0,0,0,0), (0,16,0,0), (0,0,0,16), (0,16,0,16), then the same with n=16.
  - Single sched_done; tile_cnt=8.
REQ-040 conv_tile_done on the same cycle as conv_tile_start -> ignored; the tile completes only on a later conv_tile_done.
  - Check launch-to-launch spacing = done delay + 2.
REQ-041 sched_start pulsed during WAIT of tile 3 -> no effect; the layer still ends with exactly 8 tiles.
REQ-042 rst low during WAIT of tile 5, then released -> outputs 0 and state IDLE; a new sched_start restarts at bases 0 with tile_cnt 0.
REQ-043 Set N=Tn, M=Tm, R=Tr, C=Tc; run one layer -> one tile.
  - sched_done exactly 2 cycles after conv_tile_done.
  - With TILE_SCHED_PERF_CNT_EN defined and a done delay of 10, busy_cycles=10.

Source files
------------

// File: rtl/conv_tile_sched.sv
// Layer tile scheduler: walks (n, row, col, m) tile origins and hands each tile to the conv engine.
// Optional TILE_SCHED_PERF_CNT_EN adds a 32-bit busy_cycles counter of cycles spent waiting on tiles.
module conv_tile_sched #(
    parameter int CW = 16,
    parameter int N  = 32,
    parameter int M  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_start,
    output logic          sched_done,
    output logic          sched_busy,
    output logic          conv_tile_start,
    input  logic          conv_tile_done,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic [CW-1:0] tile_cnt
`ifdef TILE_SCHED_PERF_CNT_EN
    ,
    output logic [31:0]   busy_cycles
`endif
);

    // state | meaning
    // IDLE  | waiting for sched_start
    // ISSUE | launch pulse for the current tile
    // WAIT  | tile running, waiting for conv_tile_done
    // NEXT  | count the tile and step to the next origin
    // FIN   | layer done pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic [CW-1:0] STEP_N   = CW'(Tn);
    localparam logic [CW-1:0] STEP_M   = CW'(Tm);
    localparam logic [CW-1:0] STEP_ROW = CW'(Tr);
    localparam logic [CW-1:0] STEP_COL = CW'(Tc);
    localparam logic [CW-1:0] LAST_N   = CW'(N - Tn);
    localparam logic [CW-1:0] LAST_M   = CW'(M - Tm);
    localparam logic [CW-1:0] LAST_ROW = CW'(R - Tr);
    localparam logic [CW-1:0] LAST_COL = CW'(C - Tc);

    state_e        state_q, state_d;
    logic [CW-1:0] base_n_q, base_n_d;
    logic [CW-1:0] base_m_q, base_m_d;
    logic [CW-1:0] base_row_q, base_row_d;
    logic [CW-1:0] base_col_q, base_col_d;
    logic [CW-1:0] tile_cnt_q, tile_cnt_d;

    logic wrap_n, wrap_m, wrap_row, wrap_col, last_tile;

    // End-of-layer is decided from the coordinates so a narrow tile_cnt can never stop the walk early.
    always_comb begin
        wrap_m    = (base_m_q == LAST_M);
        wrap_col  = (base_col_q == LAST_COL);
        wrap_row  = (base_row_q == LAST_ROW);
        wrap_n    = (base_n_q == LAST_N);
        last_tile = wrap_m && wrap_col && wrap_row && wrap_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sched_start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (conv_tile_done) state_d = NEXT;
            NEXT:    state_d = last_tile ? FIN : ISSUE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        conv_tile_start = (state_q == ISSUE);
        sched_done      = (state_q == FIN);
        sched_busy      = (state_q != IDLE);
    end

    // On the last tile only the count advances; the origin keeps the final tile's coordinates.
    always_comb begin
        base_n_d   = base_n_q;
        base_m_d   = base_m_q;
        base_row_d = base_row_q;
        base_col_d = base_col_q;
        tile_cnt_d = tile_cnt_q;
        if (state_q == IDLE && sched_start) begin
            base_n_d   = '0;
            base_m_d   = '0;
            base_row_d = '0;
            base_col_d = '0;
            tile_cnt_d = '0;
        end else if (state_q == NEXT) begin
            tile_cnt_d = tile_cnt_q + 1'b1;
            if (!last_tile) begin
                base_m_d = wrap_m ? '0 : base_m_q + STEP_M;
                if (wrap_m) begin
                    base_col_d = wrap_col ? '0 : base_col_q + STEP_COL;
                end
                if (wrap_m && wrap_col) begin
                    base_row_d = wrap_row ? '0 : base_row_q + STEP_ROW;
                end
                if (wrap_m && wrap_col && wrap_row) begin
                    base_n_d = base_n_q + STEP_N;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_n_q   <= '0;
            base_m_q   <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
            tile_cnt_q <= '0;
        end else begin
            base_n_q   <= base_n_d;
            base_m_q   <= base_m_d;
            base_row_q <= base_row_d;
            base_col_q <= base_col_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign tile_base_n   = base_n_q;
    assign tile_base_m   = base_m_q;
    assign tile_base_row = base_row_q;
    assign tile_base_col = base_col_q;
    assign tile_cnt      = tile_cnt_q;

`ifdef TILE_SCHED_PERF_CNT_EN
    logic [31:0] busy_cycles_q, busy_cycles_d;

    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if (state_q == IDLE && sched_start) begin
            busy_cycles_d = '0;
        end else if (state_q == WAIT) begin
            busy_cycles_d = busy_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cycles_q <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: directed tile table, corner sequences and randomized layers against a loop-nest model.
module tb_conv_tile_sched;

    localparam int CW = 16;
    localparam int N  = 32, M = 32, R = 64, C = 32;
    localparam int TN = 16, TM = 16, TR = 64, TC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sched_start = 1'b0, conv_tile_done = 1'b0;
    logic sched_done, sched_busy, conv_tile_start;
    logic [CW-1:0] bn, bm, brow, bcol, tcnt;
    logic start1 = 1'b0, done1 = 1'b0;
    logic sdone1, sbusy1, tstart1;
    logic [CW-1:0] bn1, bm1, brow1, bcol1, tcnt1;
`ifdef TILE_SCHED_PERF_CNT_EN
    logic [31:0] bc0, bc1;
`endif

    always #5 clk = ~clk;

    conv_tile_sched #(.CW(CW)) dut (
        .clk(clk), .rst(rst), .sched_start(sched_start), .sched_done(sched_done),
        .sched_busy(sched_busy), .conv_tile_start(conv_tile_start), .conv_tile_done(conv_tile_done),
        .tile_base_n(bn), .tile_base_m(bm), .tile_base_row(brow), .tile_base_col(bcol), .tile_cnt(tcnt)
`ifdef TILE_SCHED_PERF_CNT_EN
        , .busy_cycles(bc0)
`endif
    );

    conv_tile_sched #(.CW(CW), .N(16), .M(16), .R(64), .C(16)) dut1 (
        .clk(clk), .rst(rst), .sched_start(start1), .sched_done(sdone1),
        .sched_busy(sbusy1), .conv_tile_start(tstart1), .conv_tile_done(done1),
        .tile_base_n(bn1), .tile_base_m(bm1), .tile_base_row(brow1), .tile_base_col(bcol1), .tile_cnt(tcnt1)
`ifdef TILE_SCHED_PERF_CNT_EN
        , .busy_cycles(bc1)
`endif
    );

    typedef struct {
        int          dly;
        bit          dai;
        logic [15:0] n, m, row, col;
    } vec_t;
    typedef struct {
        logic [15:0] n, m, row, col;
    } crd_t;

    vec_t tbl[8];
    crd_t exp_q[$];
    int   dly_q[$];
    bit   dai_q[$];
    int   n_cmp = 0, n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_base(input string name, input crd_t e);
        chk({name, ".n"}, 32'(bn), 32'(e.n));
        chk({name, ".m"}, 32'(bm), 32'(e.m));
        chk({name, ".row"}, 32'(brow), 32'(e.row));
        chk({name, ".col"}, 32'(bcol), 32'(e.col));
    endtask

    // Reference tile order: n outermost, then row, col, m innermost.
    function automatic void build_model();
        crd_t t;
        exp_q.delete();
        for (int n = 0; n < N; n += TN)
            for (int r = 0; r < R; r += TR)
                for (int c = 0; c < C; c += TC)
                    for (int m = 0; m < M; m += TM) begin
                        t.n = 16'(n); t.m = 16'(m); t.row = 16'(r); t.col = 16'(c);
                        exp_q.push_back(t);
                    end
    endfunction

    task automatic run_layer(input int spur_tile, input int rst_tile);
        int   wait_sum;
        crd_t last;
        wait_sum = 0;
        sched_start = 1'b1;
        tick();
        sched_start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("launch", 32'(conv_tile_start), 1);
            chk("busy_issue", 32'(sched_busy), 1);
            chk("cnt_issue", 32'(tcnt), 32'(i));
            chk_base("base_issue", exp_q[i]);
            wait_sum += dly_q[i];
            if (dai_q[i]) conv_tile_done = 1'b1;
            tick();
            conv_tile_done = 1'b0;
            for (int k = 1; k < dly_q[i]; k++) begin
                chk("no_launch_wait", 32'(conv_tile_start), 0);
                chk("no_done_wait", 32'(sched_done), 0);
                chk_base("base_wait", exp_q[i]);
                if (i == rst_tile && k == 2) begin
                    rst = 1'b0;
                    #1;
                    chk("rst_start", 32'(conv_tile_start), 0);
                    chk("rst_done", 32'(sched_done), 0);
                    chk("rst_busy", 32'(sched_busy), 0);
                    chk("rst_cnt", 32'(tcnt), 0);
                    chk_base("rst_base", '{16'd0, 16'd0, 16'd0, 16'd0});
                    tick();
                    rst = 1'b1;
                    tick();
                    chk("post_rst_busy", 32'(sched_busy), 0);
                    chk("post_rst_done", 32'(sched_done), 0);
                    tick();
                    chk("post_rst_start", 32'(conv_tile_start), 0);
                    return;
                end
                if (i == spur_tile && k == 1) sched_start = 1'b1;
                tick();
                sched_start = 1'b0;
            end
            conv_tile_done = 1'b1;
            tick();
            conv_tile_done = 1'b0;
            chk("next_no_launch", 32'(conv_tile_start), 0);
            chk("next_no_done", 32'(sched_done), 0);
            chk("next_busy", 32'(sched_busy), 1);
            tick();
        end
        last = exp_q[exp_q.size() - 1];
        chk("fin_done", 32'(sched_done), 1);
        chk("fin_no_launch", 32'(conv_tile_start), 0);
        chk("fin_busy", 32'(sched_busy), 1);
        chk("fin_cnt", 32'(tcnt), 32'(exp_q.size()));
        chk_base("fin_base", last);
`ifdef TILE_SCHED_PERF_CNT_EN
        chk("busy_cycles", bc0, 32'(wait_sum));
`endif
        tick();
        chk("idle_done", 32'(sched_done), 0);
        chk("idle_busy", 32'(sched_busy), 0);
        chk("hold_cnt", 32'(tcnt), 32'(exp_q.size()));
        chk_base("hold_base", last);
        tick();
        chk("idle_no_launch", 32'(conv_tile_start), 0);
    endtask

    task automatic fill_dly(input int dly, input bit dai);
        dly_q.delete();
        dai_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            dly_q.push_back(dly);
            dai_q.push_back(dai);
        end
    endtask

    initial begin
        tbl[0] = '{10, 1'b0, 16'd0,  16'd0,  16'd0, 16'd0};
        tbl[1] = '{10, 1'b0, 16'd0,  16'd16, 16'd0, 16'd0};
        tbl[2] = '{10, 1'b0, 16'd0,  16'd0,  16'd0, 16'd16};
        tbl[3] = '{10, 1'b0, 16'd0,  16'd16, 16'd0, 16'd16};
        tbl[4] = '{10, 1'b0, 16'd16, 16'd0,  16'd0, 16'd0};
        tbl[5] = '{10, 1'b0, 16'd16, 16'd16, 16'd0, 16'd0};
        tbl[6] = '{10, 1'b0, 16'd16, 16'd0,  16'd0, 16'd16};
        tbl[7] = '{10, 1'b0, 16'd16, 16'd16, 16'd0, 16'd16};

        #3 rst = 1'b0;
        tick();
        chk("reset_start", 32'(conv_tile_start), 0);
        chk("reset_done", 32'(sched_done), 0);
        chk("reset_busy", 32'(sched_busy), 0);
        chk("reset_cnt", 32'(tcnt), 0);
        chk_base("reset_base", '{16'd0, 16'd0, 16'd0, 16'd0});
        rst = 1'b1;
        tick();
        chk("idle_after_reset", 32'(sched_busy), 0);

        // directed layer from the vector table
        exp_q.delete(); dly_q.delete(); dai_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{tbl[i].n, tbl[i].m, tbl[i].row, tbl[i].col});
            dly_q.push_back(tbl[i].dly);
            dai_q.push_back(tbl[i].dai);
        end
        run_layer(-1, -1);

        // done coinciding with every launch must be ignored
        build_model();
        fill_dly(5, 1'b1);
        run_layer(-1, -1);

        // stray sched_start during WAIT of tile 3
        fill_dly(4, 1'b0);
        run_layer(2, -1);

        // reset during WAIT of tile 5, then a clean restart
        fill_dly(6, 1'b0);
        run_layer(-1, 4);
        fill_dly(3, 1'b0);
        run_layer(-1, -1);

        // randomized layers
        for (int l = 0; l < 4; l++) begin
            dly_q.delete();
            dai_q.delete();
            for (int i = 0; i < exp_q.size(); i++) begin
                dly_q.push_back(int'($urandom_range(2, 9)));
                dai_q.push_back(1'($urandom_range(0, 1)));
            end
            run_layer(int'($urandom_range(0, 9)), -1);
        end

        // single-tile layer
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("one_launch", 32'(tstart1), 1);
        chk("one_cnt0", 32'(tcnt1), 0);
        chk("one_base", 32'({bn1, bm1} | {brow1, bcol1}), 0);
        tick();
        for (int k = 1; k < 10; k++) begin
            chk("one_wait_done", 32'(sdone1), 0);
            tick();
        end
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk("one_next_done", 32'(sdone1), 0);
        tick();
        chk("one_fin_done", 32'(sdone1), 1);
        chk("one_fin_cnt", 32'(tcnt1), 1);
`ifdef TILE_SCHED_PERF_CNT_EN
        chk("one_busy_cycles", bc1, 10);
`endif
        tick();
        chk("one_idle_done", 32'(sdone1), 0);
        chk("one_idle_busy", 32'(sbusy1), 0);
`ifdef TILE_SCHED_PERF_CNT_EN
        chk("one_busy_hold", bc1, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
